// File: rtl/axi_mem_master.sv
// axi_mem_master: single-outstanding AXI4 master behind a simple req/resp port.
// Define AXI_BURST_EN for multi-beat INCR reads (arlen = req_len).
module axi_mem_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_WR, S_B
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_size;
  logic [7:0]  r_cnt;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_last;
  logic        r_resp_err;

  logic        w_acc;
  logic        w_rbeat;
  logic        w_bhs;
  logic        w_awhs;
  logic        w_whs;
  logic        w_cnt_zero;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic [7:0]  w_len;

  assign w_acc      = req_valid & req_ready;
  assign w_rbeat    = rvalid & rready;
  assign w_bhs      = bvalid & bready;
  assign w_awhs     = awvalid & awready;
  assign w_whs      = wvalid & wready;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_aw_fin   = r_aw_done | w_awhs;
  assign w_w_fin    = r_w_done | w_whs;

`ifdef AXI_BURST_EN
  assign w_len = req_len;
  // Counter is untouched until the first beat, so it doubles as arlen.
  assign arlen = r_cnt;
`else
  logic w_unused_len;
  assign w_unused_len = ^req_len;
  assign w_len = 8'd0;
  assign arlen = 8'd0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_acc) w_next = req_write ? S_WR : S_AR;
      S_AR:
        if (arready) w_next = S_R;
      S_R:
        if (w_rbeat && rlast) w_next = S_IDLE;
      S_WR:
        if (w_aw_fin && w_w_fin) w_next = S_B;
      S_B:
        if (bvalid) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    arvalid   = (r_state == S_AR);
    rready    = (r_state == S_R);
    awvalid   = (r_state == S_WR) && !r_aw_done;
    wvalid    = (r_state == S_WR) && !r_w_done;
    bready    = (r_state == S_B);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      r_resp_valid <= w_rbeat | w_bhs;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_acc) begin
        r_cnt     <= w_len;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_awhs) r_aw_done <= 1'b1;
      if (w_whs)  r_w_done  <= 1'b1;
      if (w_rbeat) begin
        r_resp_last <= w_cnt_zero;
        r_resp_err  <= (rresp != 2'b00)
                     | (rlast != w_cnt_zero)
                     | (rid != AXI_ID);
        if (!w_cnt_zero) r_cnt <= r_cnt - 8'd1;
      end
      if (w_bhs) begin
        r_resp_last <= 1'b1;
        r_resp_err  <= (bresp != 2'b00)
                     | (bid != AXI_ID);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
      r_size  <= req_size;
    end
    if (w_rbeat)    r_resp_rdata <= rdata;
    else if (w_bhs) r_resp_rdata <= 32'd0;
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_last  = r_resp_last;
  assign resp_err   = r_resp_err;

  assign awaddr  = r_addr;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = r_size;
  assign awburst = 2'b01;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;

  assign araddr  = r_addr;
  assign arid    = AXI_ID;
  assign arsize  = r_size;
  assign arburst = 2'b01;

endmodule
